dcache_wt: RTL and testbench
============================

Name: dcache_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU load/store unit and the AXI bridge, with the same CPU and bridge port set as the earlier pass-through dcache.
- Adds tag/data storage, line refill, hit reporting, uncached bypass and CACOP invalidation.

Parameters:
- INDEX_BITS, 6, number of sets = 2^INDEX_BITS.
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..4.
- Derived:
  - OFF_BITS = log2(LINE_WORDS)+2.
  - TAG_BITS = 32-INDEX_BITS-OFF_BITS.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- valid  in  1  CPU request valid.
- ready  out  1  request accepted when valid&&ready.
- op  in  1  0 read, 1 write.
- addr  in  32  byte address, word aligned.
- uncached  in  1  bypass cache for this request.
- rvalid  out  1  read data valid, one-cycle pulse.
- rdata  out  32  read data.
- rhit  out  1  with rvalid: served from cache.
- awstrb  in  4  write byte strobes.
- wdata  in  32  write data.
- whit  out  1  pulse: cached write hit updated the array.
- cacop_valid  in  1  cache-op request.
- cacop_ready  out  1  cache-op accepted when cacop_valid&&cacop_ready.
- cacop_code  in  2  0 index-init, 1 index-invalidate, 2 hit-invalidate, 3 no-op.
- cacop_addr  in  32  cache-op address.
- rd_req  out  1  bridge read request.
- rd_type  out  3  3'b010 word, 3'b100 line.
- rd_addr  out  32  read address.
- rd_rdy  in  1  bridge accepts read.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  final beat.
- ret_data  in  32  beat data.
- wr_req  out  1  bridge write request.
- wr_type  out  3  always 3'b010.
- wr_addr  out  32  write address.
- wr_wstrb  out  4  write strobes.
- wr_data  out  128  {96'b0, word}.
- wr_rdy  in  1  bridge accepts write.

Behaviour:
- Storage:
  - valid bit, tag and LINE_WORDS words per set, in registers.
  - Reset clears all valid bits and sets state to IDLE; data and tags are not cleared.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, WR_REQ.
- IDLE:
  - cacop_ready=1.
  - ready = !cacop_valid (cacop has priority).
  - On accept, latch op/addr/uncached/awstrb/wdata and go to LOOKUP.
  - On cacop accept, act in that cycle and stay in IDLE:
    - code 0 and 1: clear the valid bit at cacop_addr index.
    - code 2: clear it only if the tag matches and the line is valid.
    - code 3: no effect.
- LOOKUP (one cycle), hit = !uncached && valid[idx] && tag match:
  - Read hit: rvalid=1, rhit=1, rdata = selected word; go to IDLE. Load-hit latency is 2 cycles from accept.
  - Read miss or uncached read: go to MISS_REQ.
  - Write: if hit, merge wdata into the array per awstrb and pulse whit=1. Always go to WR_REQ. No allocation on miss.
- MISS_REQ:
  - Hold rd_req=1 until rd_rdy, then go to REFILL.
  - Cached: rd_type=3'b100, rd_addr = line-aligned address.
  - Uncached: rd_type=3'b010, rd_addr = addr&~3.
- REFILL:
  - A beat counter (log2(LINE_WORDS) bits, wraps) indexes each ret_valid beat.
  - Cached: write each beat into the line; capture the beat whose index equals the requested word.
  - On ret_valid&&ret_last: set tag and valid (cached only), pulse rvalid=1 with rhit=0, go to IDLE.
  - rdata = ret_data for uncached, the captured word for cached.
  - Early ret_last: the line is still installed; words not received are undefined.
- WR_REQ:
  - Hold wr_req=1 with wr_addr = addr&~3, wr_wstrb = awstrb, wr_data = {96'b0, wdata}.
  - On wr_rdy go to IDLE.
- All bridge outputs are 0 outside MISS_REQ/WR_REQ. rd_addr and wr_addr are 0 when their request is low.
- cacop_valid outside IDLE is not accepted (cacop_ready=0).
- Reset mid-operation:
  - Abandon the transaction and go to IDLE next cycle.
  - rvalid, rhit, whit, rd_req, wr_req are 0 from the cycle after reset.
  - The bridge is reset simultaneously.
- Output reset values: ready=0 during reset, cacop_ready=0, all pulses and requests 0.

Optional Feature:
- DCACHE_WT_STAT_EN defined:
  - Adds output ports hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - Counted at LOOKUP for cached requests only: hit_cnt += 1 on read or write hit, miss_cnt += 1 on read or write miss.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Read miss then hit:
  - After reset, read 0x1C00_0104 with LINE_WORDS=4.
  - Expect rd_req with rd_type=3'b100, rd_addr=0x1C00_0100.
  - Return beats 0xA0,0xA1,0xA2,0xA3 (last on 4th); expect rvalid, rdata=0xA1, rhit=0.
  - Re-read 0x1C00_0104: no rd_req, rvalid 2 cycles after accept, rdata=0xA1, rhit=1.
- Write hit: on the cached line, write 0x1C00_0108, wdata=0x1122_3344, awstrb=4'b0011.
  - Expect whit=1.
  - Expect wr_req with wr_addr=0x1C00_0108, wr_data=0x...3344, wr_wstrb=4'b0011.
  - A subsequent read returns 0x0000_3344 (upper bytes from 0xA2), rhit=1.
- Write miss: write 0x2000_0000; expect whit=0 and wr_req. A following read of 0x2000_0000 misses with rd_type=3'b100.
- Uncached read: uncached=1, read 0x1C00_0104 while cached.
  - Expect rd_type=3'b010, rd_addr=0x1C00_0104; single beat 0x55 gives rdata=0x55, rhit=0.
  - Cached line is unchanged.
- CACOP: hit-invalidate (code 2) 0x1C00_0100 accepted in IDLE; next read of 0x1C00_0104 misses.
  - cacop_valid together with valid: cacop accepted and ready=0 that cycle.
- Reset mid-refill: assert reset after the 2nd beat.
  - Expect IDLE, rvalid=0, and a re-read of the same address misses (valid bit cleared).

Source files
------------

// File: rtl/dcache_wt.sv
`default_nettype none
//==============================================================================
// Module      : dcache_wt
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               placed between the CPU load/store unit and the AXI bridge.
//               Tag/valid/data storage lives in registers. Cached read misses
//               refill a whole line. Uncached reads fetch a single word.
//               Every write is forwarded to the bridge. A write that hits also
//               updates the local copy of the line. CACOP requests can
//               invalidate a line by index or by hit.
//
// Ports       : clock, reset          - clock and synchronous active-high reset
//               valid/ready/op/addr/uncached/awstrb/wdata
//                                     - CPU request channel
//               rvalid/rdata/rhit     - read response (one-cycle pulse)
//               whit                  - pulse when a cached write hit the array
//               cacop_valid/ready/code/addr
//                                     - cache maintenance request
//               rd_req/rd_type/rd_addr/rd_rdy
//                                     - bridge read request
//               ret_valid/ret_last/ret_data
//                                     - bridge read return beats
//               wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy
//                                     - bridge write request
//               hit_cnt/miss_cnt      - cached lookup statistics
//                                       (only with DCACHE_WT_STAT_EN)
//
// Option      : define DCACHE_WT_STAT_EN to add the hit/miss counters.
//
// Revision    : 1.0 - initial release
//==============================================================================
module dcache_wt #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid,
    output logic          ready,
    input  logic          op,
    input  logic [31:0]   addr,
    input  logic          uncached,
    output logic          rvalid,
    output logic [31:0]   rdata,
    output logic          rhit,
    input  logic [3:0]    awstrb,
    input  logic [31:0]   wdata,
    output logic          whit,
    input  logic          cacop_valid,
    output logic          cacop_ready,
    input  logic [1:0]    cacop_code,
    input  logic [31:0]   cacop_addr,
    output logic          rd_req,
    output logic [2:0]    rd_type,
    output logic [31:0]   rd_addr,
    input  logic          rd_rdy,
    input  logic          ret_valid,
    input  logic          ret_last,
    input  logic [31:0]   ret_data,
    output logic          wr_req,
    output logic [2:0]    wr_type,
    output logic [31:0]   wr_addr,
    output logic [3:0]    wr_wstrb,
    output logic [127:0]  wr_data,
    input  logic          wr_rdy
`ifdef DCACHE_WT_STAT_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS  = WORD_BITS + 2;
    localparam int TAG_BITS  = 32 - INDEX_BITS - OFF_BITS;
    localparam int SETS      = 1 << INDEX_BITS;

    localparam logic [2:0] c_TYPE_WORD = 3'b010;
    localparam logic [2:0] c_TYPE_LINE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MISS_REQ = 3'd2,
        S_REFILL   = 3'd3,
        S_WR_REQ   = 3'd4
    } state_t;

    state_t                 r_state;

    // Storage: only the valid bits are reset, tags and data are don't-care
    // until their line becomes valid.
    logic [SETS-1:0]        r_line_valid;
    logic [TAG_BITS-1:0]    r_tag  [SETS];
    logic [31:0]            r_data [SETS][LINE_WORDS];

    // Request captured at accept
    logic                   r_op;
    logic [31:0]            r_addr;
    logic                   r_uncached;
    logic [3:0]             r_awstrb;
    logic [31:0]            r_wdata;

    logic [WORD_BITS-1:0]   r_beat;
    logic [31:0]            r_capture;
    logic                   r_rvalid;
    logic                   r_rhit;
    logic                   r_whit;
    logic [31:0]            r_rdata;

    logic [INDEX_BITS-1:0]  w_idx;
    logic [TAG_BITS-1:0]    w_tag;
    logic [WORD_BITS-1:0]   w_word;
    logic                   w_hit;
    logic [31:0]            w_hit_word;
    logic [31:0]            w_merged;
    logic [INDEX_BITS-1:0]  w_cop_idx;
    logic [TAG_BITS-1:0]    w_cop_tag;
    logic                   w_beat_is_req;
    logic                   w_unused;

    assign w_idx         = r_addr[OFF_BITS +: INDEX_BITS];
    assign w_tag         = r_addr[31 -: TAG_BITS];
    assign w_word        = r_addr[2 +: WORD_BITS];
    assign w_hit         = !r_uncached && r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_word    = r_data[w_idx][w_word];
    assign w_cop_idx     = cacop_addr[OFF_BITS +: INDEX_BITS];
    assign w_cop_tag     = cacop_addr[31 -: TAG_BITS];
    assign w_beat_is_req = (r_beat == w_word);
    assign w_unused      = ^{r_addr[1:0], cacop_addr[OFF_BITS-1:0]};

    // Byte-merge of the store data into the currently stored word
    always_comb begin
        w_merged = w_hit_word;
        for (int b = 0; b < 4; b++) begin
            if (r_awstrb[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    // Control FSM, valid bits and registered response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_line_valid <= '0;
            r_rvalid     <= 1'b0;
            r_rhit       <= 1'b0;
            r_whit       <= 1'b0;
            r_beat       <= '0;
        end else begin
            r_rvalid <= 1'b0;
            r_rhit   <= 1'b0;
            r_whit   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cacop_valid) begin
                        case (cacop_code)
                            2'd0, 2'd1: r_line_valid[w_cop_idx] <= 1'b0;
                            2'd2: begin
                                if (r_line_valid[w_cop_idx] && (r_tag[w_cop_idx] == w_cop_tag)) begin
                                    r_line_valid[w_cop_idx] <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end else if (valid) begin
                        r_op       <= op;
                        r_addr     <= addr;
                        r_uncached <= uncached;
                        r_awstrb   <= awstrb;
                        r_wdata    <= wdata;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!r_op) begin
                        if (w_hit) begin
                            r_rvalid <= 1'b1;
                            r_rhit   <= 1'b1;
                            r_rdata  <= w_hit_word;
                            r_state  <= S_IDLE;
                        end else begin
                            r_state  <= S_MISS_REQ;
                        end
                    end else begin
                        r_whit  <= w_hit;
                        r_state <= S_WR_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (rd_rdy) begin
                        r_beat  <= '0;
                        r_state <= S_REFILL;
                        // The line is overwritten beat by beat, so it must not
                        // look valid under its old tag while the refill runs.
                        if (!r_uncached) begin
                            r_line_valid[w_idx] <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (ret_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_beat_is_req) begin
                            r_capture <= ret_data;
                        end
                        if (ret_last) begin
                            r_rvalid <= 1'b1;
                            r_state  <= S_IDLE;
                            if (r_uncached) begin
                                r_rdata <= ret_data;
                            end else begin
                                r_rdata             <= w_beat_is_req ? ret_data : r_capture;
                                r_line_valid[w_idx] <= 1'b1;
                            end
                        end
                    end
                end
                S_WR_REQ: begin
                    if (wr_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays (not reset)
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == S_LOOKUP && r_op && w_hit) begin
                r_data[w_idx][w_word] <= w_merged;
            end
            if (r_state == S_REFILL && ret_valid && !r_uncached) begin
                r_data[w_idx][r_beat] <= ret_data;
                if (ret_last) begin
                    r_tag[w_idx] <= w_tag;
                end
            end
        end
    end

`ifdef DCACHE_WT_STAT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP && !r_uncached) begin
            if (w_hit) begin
                r_hit_cnt  <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    // CPU side
    assign ready       = !reset && (r_state == S_IDLE) && !cacop_valid;
    assign cacop_ready = !reset && (r_state == S_IDLE);
    assign rvalid      = r_rvalid;
    assign rhit        = r_rhit;
    assign rdata       = r_rdata;
    assign whit        = r_whit;

    // Bridge side: everything is zero unless the matching request is up
    assign rd_req   = (r_state == S_MISS_REQ);
    assign rd_type  = !rd_req ? 3'b000 : (r_uncached ? c_TYPE_WORD : c_TYPE_LINE);
    assign rd_addr  = !rd_req ? 32'h0
                    : (r_uncached ? {r_addr[31:2], 2'b00}
                                  : {r_addr[31:OFF_BITS], {OFF_BITS{1'b0}}});
    assign wr_req   = (r_state == S_WR_REQ);
    assign wr_type  = wr_req ? c_TYPE_WORD : 3'b000;
    assign wr_addr  = wr_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign wr_wstrb = wr_req ? r_awstrb : 4'h0;
    assign wr_data  = wr_req ? {96'h0, r_wdata} : 128'h0;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
//==============================================================================
// Module      : tb_dcache_wt
// Description : Self-checking bench for dcache_wt. A table of CPU requests
//               with their expected bridge traffic and responses is replayed
//               through a small bridge responder; read responses are checked
//               through a scoreboard queue. Hand-written sequences cover
//               CACOP and reset during a refill.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dcache_wt;

    logic         clock;
    logic         reset;
    logic         valid;
    logic         ready;
    logic         op;
    logic [31:0]  addr;
    logic         uncached;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         rhit;
    logic [3:0]   awstrb;
    logic [31:0]  wdata;
    logic         whit;
    logic         cacop_valid;
    logic         cacop_ready;
    logic [1:0]   cacop_code;
    logic [31:0]  cacop_addr;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    dcache_wt #(.INDEX_BITS(6), .LINE_WORDS(4)) dut (
        .clock(clock), .reset(reset),
        .valid(valid), .ready(ready), .op(op), .addr(addr), .uncached(uncached),
        .rvalid(rvalid), .rdata(rdata), .rhit(rhit),
        .awstrb(awstrb), .wdata(wdata), .whit(whit),
        .cacop_valid(cacop_valid), .cacop_ready(cacop_ready),
        .cacop_code(cacop_code), .cacop_addr(cacop_addr),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic        unc;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        miss;      // a bridge read is expected
        logic [2:0]  rd_type;
        logic [31:0] rd_addr;
        logic [31:0] base;      // beat i returns base+i
        int          nbeats;
        logic [31:0] rdata;
        logic        rhit;
        logic        whit;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rhit;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   checks;
    int   errors;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        bit   done;
        bit   saw_rd;
        bit   saw_wr;
        bit   saw_whit;
        exp_t e;
        valid    = 1'b1;
        op       = v.op;
        addr     = v.addr;
        uncached = v.unc;
        awstrb   = v.strb;
        wdata    = v.wdata;
        cyc = 0;
        while (!ready && cyc < 20) begin
            tick;
            cyc++;
        end
        check("req_ready", ready, 1'b1);
        if (!v.op) begin
            sb.push_back('{rdata: v.rdata, rhit: v.rhit});
        end
        tick;
        valid = 1'b0;
        cyc = 1; done = 0; saw_rd = 0; saw_wr = 0; saw_whit = 0;
        while (!done && cyc < 60) begin
            if (whit) saw_whit = 1;
            if (rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", rvalid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", rdata, e.rdata);
                    check("rhit", rhit, e.rhit);
                    if (e.rhit) check("hit_latency", cyc, 2);
                end
                done = 1;
            end else if (rd_req) begin
                saw_rd = 1;
                check("rd_type", rd_type, v.rd_type);
                check("rd_addr", rd_addr, v.rd_addr);
                rd_rdy = 1'b1;
                tick; cyc++;
                rd_rdy = 1'b0;
                for (int i = 0; i < v.nbeats; i++) begin
                    ret_valid = 1'b1;
                    ret_data  = v.base + 32'(i);
                    ret_last  = (i == v.nbeats - 1);
                    tick; cyc++;
                end
                ret_valid = 1'b0;
                ret_last  = 1'b0;
                continue;
            end else if (wr_req) begin
                saw_wr = 1;
                check("wr_type", wr_type, 3'b010);
                check("wr_addr", wr_addr, {v.addr[31:2], 2'b00});
                check("wr_wstrb", wr_wstrb, v.strb);
                check("wr_data", wr_data, {96'h0, v.wdata});
                wr_rdy = 1'b1;
                tick; cyc++;
                wr_rdy = 1'b0;
                done = 1;
            end
            if (!done) begin
                tick; cyc++;
            end
        end
        check("txn_done", done, 1'b1);
        check("saw_rd_req", saw_rd, v.miss);
        check("saw_wr_req", saw_wr, v.op);
        check("whit", saw_whit, v.whit);
    endtask

    task automatic do_cacop(input logic [1:0] code, input logic [31:0] a, input bit with_req);
        cacop_valid = 1'b1;
        cacop_code  = code;
        cacop_addr  = a;
        if (with_req) begin
            valid = 1'b1; op = 1'b0; addr = a; uncached = 1'b0;
        end
        #1;
        check("cacop_ready", cacop_ready, 1'b1);
        if (with_req) check("ready_vs_cacop", ready, 1'b0);
        tick;
        cacop_valid = 1'b0;
        valid = 1'b0;
        #1;
        check("idle_after_cacop", ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; valid = 1'b0; op = 1'b0; addr = 32'h0; uncached = 1'b0;
        awstrb = 4'h0; wdata = 32'h0; cacop_valid = 1'b0; cacop_code = 2'd0;
        cacop_addr = 32'h0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        ret_data = 32'h0; wr_rdy = 1'b0;

        //             op    addr          unc   strb   wdata         miss  rd_type  rd_addr       base    nb  rdata         rhit  whit
        tbl[0] = '{1'b0, 32'h1C00_0104, 1'b0, 4'h0,  32'h0,        1'b1, 3'b100, 32'h1C00_0100, 32'hA0, 4, 32'h0000_00A1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h1C00_0104, 1'b0, 4'h0,  32'h0,        1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0000_00A1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h1C00_0108, 1'b0, 4'h3,  32'h1122_3344, 1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0,         1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'h1C00_0108, 1'b0, 4'h0,  32'h0,        1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0000_3344, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'h2000_0000, 1'b0, 4'hF,  32'hCAFE_F00D, 1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0,         1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h2000_0000, 1'b0, 4'h0,  32'h0,        1'b1, 3'b100, 32'h2000_0000, 32'hB0, 4, 32'h0000_00B0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 32'h1C00_0104, 1'b1, 4'h0,  32'h0,        1'b1, 3'b010, 32'h1C00_0104, 32'h55, 1, 32'h0000_0055, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 32'h1C00_0104, 1'b1, 4'hF,  32'hDEAD_BEEF, 1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0,         1'b0, 1'b0};
        tbl[8] = '{1'b0, 32'h1C00_0104, 1'b0, 4'h0,  32'h0,        1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0000_00A1, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 32'h1C00_010C, 1'b0, 4'h0,  32'h0,        1'b0, 3'b000, 32'h0,         32'h0,  0, 32'h0000_00A3, 1'b1, 1'b0};

        // Reset state
        tick; tick;
        check("rst_ready", ready, 1'b0);
        check("rst_cacop_ready", cacop_ready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_whit", whit, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_wr_req", wr_req, 1'b0);
        reset = 1'b0;
        #1;
        check("idle_ready", ready, 1'b1);
        check("idle_cacop_ready", cacop_ready, 1'b1);
        check("idle_rd_addr", rd_addr, 32'h0);
        check("idle_wr_addr", wr_addr, 32'h0);
        check("idle_wr_data", wr_data, 128'h0);

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i]);
        end

        // Hit-invalidate issued together with a request: cacop wins
        do_cacop(2'd2, 32'h1C00_0100, 1'b1);
        run_vec('{1'b0, 32'h1C00_0104, 1'b0, 4'h0, 32'h0, 1'b1, 3'b100, 32'h1C00_0100, 32'hC0, 4, 32'h0000_00C1, 1'b0, 1'b0});
        // Hit-invalidate with a different tag leaves the line alone
        do_cacop(2'd2, 32'h3C00_0100, 1'b0);
        run_vec('{1'b0, 32'h1C00_0104, 1'b0, 4'h0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 32'h0000_00C1, 1'b1, 1'b0});
        // Index-invalidate ignores the tag; requested word is the last beat
        do_cacop(2'd1, 32'h0000_0100, 1'b0);
        run_vec('{1'b0, 32'h1C00_010C, 1'b0, 4'h0, 32'h0, 1'b1, 3'b100, 32'h1C00_0100, 32'hD0, 4, 32'h0000_00D3, 1'b0, 1'b0});
        // No-op code
        do_cacop(2'd3, 32'h1C00_0100, 1'b0);
        run_vec('{1'b0, 32'h1C00_0100, 1'b0, 4'h0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 32'h0000_00D0, 1'b1, 1'b0});

        // Reset in the middle of a refill
        valid = 1'b1; op = 1'b0; addr = 32'h3000_0204; uncached = 1'b0;
        tick;
        valid = 1'b0;
        tick;
        check("mid_rd_req", rd_req, 1'b1);
        rd_rdy = 1'b1;
        tick;
        rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1; ret_data = 32'hE0 + 32'(i); ret_last = 1'b0;
            tick;
        end
        ret_valid = 1'b0;
        check("mid_cacop_ready", cacop_ready, 1'b0);
        check("mid_rvalid", rvalid, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", ready, 1'b0);
        tick;
        reset = 1'b0;
        #1;
        check("post_rst_rvalid", rvalid, 1'b0);
        check("post_rst_rd_req", rd_req, 1'b0);
        check("post_rst_ready", ready, 1'b1);
        run_vec('{1'b0, 32'h3000_0204, 1'b0, 4'h0, 32'h0, 1'b1, 3'b100, 32'h3000_0200, 32'hF0, 4, 32'h0000_00F1, 1'b0, 1'b0});
        // Reset also cleared every other line
        run_vec('{1'b0, 32'h1C00_0104, 1'b0, 4'h0, 32'h0, 1'b1, 3'b100, 32'h1C00_0100, 32'h70, 4, 32'h0000_0071, 1'b0, 1'b0});

        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
